// File: rtl/opl3_reg_write_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : opl3_reg_write_queue
//  Description : Host-to-OPL3 register write queue. After reset it sweeps all
//                512 register addresses writing 0x00, then drains a small FIFO
//                of host writes to the chip, spacing strobes WR_GAP cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module opl3_reg_write_queue #(
  parameter int FIFO_DEPTH = 4,   // power of two, 2..16
  parameter int WR_GAP     = 4    // 1..255 cycles between queued writes
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_valid,
  input  logic [8:0] host_addr,
  input  logic [7:0] host_data,
  output logic       host_ready,
  output logic       opl3_wr,
  output logic [8:0] opl3_addr,
  output logic [7:0] opl3_data,
  output logic       init_done
);

  localparam int              PW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]   C_FULL     = CW'(FIFO_DEPTH);
  localparam logic [7:0]      C_GAP_LOAD = 8'(WR_GAP - 1);
  localparam logic [8:0]      C_LAST_REG = 9'h1FF;

  localparam logic [0:0]      ST_CLEAR   = 1'b0;
  localparam logic [0:0]      ST_RUN     = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [8:0]    r_clr_addr;

  logic [16:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_gap_cnt;

  logic          r_run_wr;
  logic [8:0]    r_run_addr;
  logic [7:0]    r_run_data;

  logic          w_wr;
  logic [8:0]    w_addr;
  logic [7:0]    w_data;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;

  assign w_push = host_valid & w_ready;
  assign w_pop  = (r_state == ST_RUN) && (r_count != '0) && (r_gap_cnt == 8'd0);

  // State register: reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_CLEAR;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave CLEAR once the last register address has been written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_addr == C_LAST_REG) w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Outputs: CLEAR drives the sweep address directly so the first write lands
  // in the first cycle out of reset; RUN uses the registered pop stage.
  always_comb begin
    w_wr    = r_run_wr;
    w_addr  = r_run_addr;
    w_data  = r_run_data;
    w_ready = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_wr   = 1'b1;
        w_addr = r_clr_addr;
        w_data = 8'h00;
      end
      ST_RUN:   w_ready = (r_count != C_FULL);
      default:  w_ready = 1'b0;
    endcase
  end

  // Reset gates the strobes combinationally so nothing leaks while it is high.
  assign opl3_wr    = w_wr & ~reset;
  assign host_ready = w_ready & ~reset;
  assign init_done  = (r_state == ST_RUN) & ~reset;
  assign opl3_addr  = w_addr;
  assign opl3_data  = w_data;

  // Sweep address: stops at 0x1FF so a second sweep can never start.
  always_ff @(posedge clk) begin
    if (reset)
      r_clr_addr <= 9'h000;
    else if ((r_state == ST_CLEAR) && (r_clr_addr != C_LAST_REG))
      r_clr_addr <= r_clr_addr + 9'd1;
  end

  // FIFO storage: data only, no reset needed since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {host_addr, host_data};
  end

  // FIFO pointers wrap naturally at FIFO_DEPTH; occupancy tracked separately.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Gap counter: reloads on each pop, counts down and saturates at zero.
  always_ff @(posedge clk) begin
    if (reset)                  r_gap_cnt <= 8'd0;
    else if (w_pop)             r_gap_cnt <= C_GAP_LOAD;
    else if (r_gap_cnt != 8'd0) r_gap_cnt <= r_gap_cnt - 8'd1;
  end

  // Pop stage: one-cycle strobe; address/data hold between strobes, and track
  // the sweep so RUN starts out holding the final 0x1FF/0x00 write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_wr   <= 1'b0;
      r_run_addr <= 9'h000;
      r_run_data <= 8'h00;
    end else if (r_state == ST_CLEAR) begin
      r_run_wr   <= 1'b0;
      r_run_addr <= r_clr_addr;
      r_run_data <= 8'h00;
    end else if (w_pop) begin
      r_run_wr   <= 1'b1;
      r_run_addr <= r_mem[r_rd_ptr][16:8];
      r_run_data <= r_mem[r_rd_ptr][7:0];
    end else begin
      r_run_wr   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opl3_reg_write_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_opl3_reg_write_queue
//  Description : Scoreboard bench for opl3_reg_write_queue. Two instances share
//                clk/reset: u_dut0 (depth 4, gap 4) and u_dut1 (depth 4, gap 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opl3_reg_write_queue;

  localparam int DEPTH = 4;
  localparam int GAP0  = 4;
  localparam int GAP1  = 1;

  typedef struct {
    logic [8:0] a;
    logic [7:0] v;
    int         acc;   // edge at which the request is accepted
    int         pe;    // edge at which its strobe is expected
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hv [2];
  logic [8:0] ha [2];
  logic [7:0] hd [2];
  logic       hrdy [2];
  logic       wr [2];
  logic       idone [2];
  logic [8:0] oa [2];
  logic [7:0] od [2];

  ent_t       sb [2][$];
  int         gapv [2];
  int         last_pe [2];
  logic [8:0] last_a [2];
  logic [7:0] last_d [2];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  int         m_occ;
  ent_t       m_e;

  opl3_reg_write_queue #(.FIFO_DEPTH(DEPTH), .WR_GAP(GAP0)) u_dut0 (
    .clk(clk), .reset(reset),
    .host_valid(hv[0]), .host_addr(ha[0]), .host_data(hd[0]), .host_ready(hrdy[0]),
    .opl3_wr(wr[0]), .opl3_addr(oa[0]), .opl3_data(od[0]), .init_done(idone[0])
  );

  opl3_reg_write_queue #(.FIFO_DEPTH(DEPTH), .WR_GAP(GAP1)) u_dut1 (
    .clk(clk), .reset(reset),
    .host_valid(hv[1]), .host_addr(ha[1]), .host_data(hd[1]), .host_ready(hrdy[1]),
    .opl3_wr(wr[1]), .opl3_addr(oa[1]), .opl3_data(od[1]), .init_done(idone[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops on strobes, checks timing/hold/ready, pushes on accepts.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        chk("wr_during_reset", 32'(wr[d]), 32'd0);
        sb[d].delete();
        last_pe[d] = -1000;
      end else if (mon_en) begin
        if (wr[d]) begin
          if (sb[d].size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            m_e = sb[d].pop_front();
            chk("strobe_addr", 32'(oa[d]), 32'(m_e.a));
            chk("strobe_data", 32'(od[d]), 32'(m_e.v));
            chk("strobe_cycle", 32'(cyc), 32'(m_e.pe));
            last_a[d] = m_e.a;
            last_d[d] = m_e.v;
          end
        end else begin
          chk("hold_addr", 32'(oa[d]), 32'(last_a[d]));
          chk("hold_data", 32'(od[d]), 32'(last_d[d]));
          if (sb[d].size() > 0 && sb[d][0].pe <= cyc) begin
            chk("missing_strobe", 32'd0, 32'd1);
            m_e = sb[d].pop_front();
          end
        end
        m_occ = 0;
        for (int k = 0; k < sb[d].size(); k++)
          if (sb[d][k].acc <= cyc) m_occ++;
        chk("host_ready", 32'(hrdy[d]), 32'(m_occ < DEPTH));
        chk("init_done_run", 32'(idone[d]), 32'd1);
        if (hv[d] && hrdy[d]) begin
          m_e.a   = ha[d];
          m_e.v   = hd[d];
          m_e.acc = cyc + 1;
          m_e.pe  = ((cyc + 2) > (last_pe[d] + gapv[d])) ? (cyc + 2) : (last_pe[d] + gapv[d]);
          last_pe[d] = m_e.pe;
          sb[d].push_back(m_e);
        end
      end
    end
  end

  // Drive one request on instance d and hold it until accepted (bounded).
  task automatic send(input int d, input logic [8:0] a, input logic [7:0] v);
    int t;
    t = 0;
    hv[d] = 1'b1;
    ha[d] = a;
    hd[d] = v;
    do begin
      @(negedge clk);
      t++;
    end while (!hrdy[d] && t < 200);
    if (!hrdy[d]) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    hv[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int t;
    t = 0;
    while (sb[d].size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", 32'(sb[d].size()), 32'd0);
  endtask

  // Called at posedge+1 right after reset drops; checks n sweep writes.
  task automatic sweep(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("sweep_wr", 32'(wr[d]), 32'd1);
        chk("sweep_addr", 32'(oa[d]), 32'(i));
        chk("sweep_data", 32'(od[d]), 32'd0);
        chk("sweep_ready", 32'(hrdy[d]), 32'd0);
        chk("sweep_init", 32'(idone[d]), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    if (full) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("init_rise", 32'(idone[d]), 32'd1);
        chk("post_sweep_wr", 32'(wr[d]), 32'd0);
        chk("post_sweep_ready", 32'(hrdy[d]), 32'd1);
        chk("post_sweep_addr", 32'(oa[d]), 32'h1FF);
        last_a[d] = 9'h1FF;
        last_d[d] = 8'h00;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_drive(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(d, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_wr", 32'(wr[d]), 32'd0);
      chk("rst_addr", 32'(oa[d]), 32'd0);
      chk("rst_data", 32'(od[d]), 32'd0);
      chk("rst_init", 32'(idone[d]), 32'd0);
      chk("rst_ready", 32'(hrdy[d]), 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hv[d] = 1'b0;
      ha[d] = '0;
      hd[d] = '0;
      last_pe[d] = -1000;
      last_a[d] = '0;
      last_d[d] = '0;
    end
    gapv[0] = GAP0;
    gapv[1] = GAP1;

    // Reset state and full clear sweep.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sweep(512, 1'b1);
    mon_en = 1'b1;

    // Single write, then nothing more.
    send(0, 9'h0B0, 8'h31);
    repeat (12) @(posedge clk);
    #1;
    chk("single_drained", 32'(sb[0].size()), 32'd0);

    // Write followed by a 4-deep burst while the gap is still counting: fills.
    send(0, 9'h0A0, 8'h55);
    for (int i = 0; i < 4; i++) send(0, 9'h020 + 9'(i), 8'(i + 1));
    @(negedge clk);
    chk("burst_full_ready", 32'(hrdy[0]), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("burst_ready_after_pop", 32'(hrdy[0]), 32'd1);
    wait_drain(0);

    // Streaming with gap 1: one strobe per cycle.
    for (int i = 0; i < 20; i++) send(1, 9'h040 + 9'(i), 8'(i));
    wait_drain(1);

    // Random traffic on both instances.
    fork
      rand_drive(0, 4000);
      rand_drive(1, 6000);
    join
    wait_drain(0);
    wait_drain(1);

    // Reset with entries pending, then a second reset mid-sweep at 0x100.
    send(0, 9'h100, 8'h11);
    send(0, 9'h101, 8'h22);
    send(0, 9'h102, 8'h33);
    mon_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sweep(256, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sweep(512, 1'b1);
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_stale_entries", 32'(sb[0].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
